// File: rtl/hazard_interlock.sv
// Load-use stall and taken-branch flush controller; drives PC / IF/ID write
// enables and the ID/EX bubble beside the operand-forwarding network.
module hazard_interlock #(
    parameter int OP_W         = 5,
    parameter int RA_W         = 5,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IR1,
    input  logic [31:0]      IR2,
    input  logic [RA_W-1:0]  RA1_1,
    input  logic [RA_W-1:0]  RA2_1,
    input  logic [RA_W-1:0]  WA_2,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             flush_ifid,
    output logic [1:0]       hazard_state,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [OP_W-1:0] OP_LW  = OP_W'(5'b01010);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(5'b01011);
    localparam logic [OP_W-1:0] OP_NOP = OP_W'(5'b00000);

    // Reload values for the remaining-cycle counter; the first cycle of a
    // stall/flush entered from RUN is already spent by the Mealy response.
    localparam logic [3:0] LS_FIRST  = 4'(LOAD_STALL - 2);
    localparam logic [3:0] FL_FIRST  = 4'(FLUSH_CYCLES - 2);
    localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [OP_W-1:0] op_id;
    logic [OP_W-1:0] op_ex;
    logic            load_use;
    logic            stall_set;
    logic            flush_set;
    logic            stall_drv;
    logic            flush_drv;

    assign op_id = IR1[31 -: OP_W];
    assign op_ex = IR2[31 -: OP_W];

    // Store-data dependence (RA2 of an SW) is resolved by MEM-stage forwarding.
    assign load_use = (op_ex == OP_LW) && (op_id != OP_NOP) &&
                      ((WA_2 == RA1_1) || ((WA_2 == RA2_1) && (op_id != OP_SW)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_set = 1'b0;
        flush_set = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    flush_set = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FL_FIRST;
                    end
                end else if (load_use) begin
                    stall_set = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = LS_FIRST;
                    end
                end
            end
            ST_STALL: begin
                stall_set = 1'b1;
                if (branch_taken) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FL_RELOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_FLUSH: begin
                flush_set = 1'b1;
                if (branch_taken) begin
                    cnt_d = FL_RELOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Saturating statistics counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_set && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Reset masks the combinational response so outputs are RUN-quiet at once.
    assign stall_drv = stall_set && rst_n;
    assign flush_drv = flush_set && rst_n;

    assign pc_write     = !stall_drv;
    assign ifid_write   = !stall_drv;
    assign idex_bubble  = stall_drv || flush_drv;
    assign flush_ifid   = flush_drv;
    assign hazard_state = state_q;
    assign stall_count  = stall_count_q;

endmodule
